// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - stream-to-frame loader feeding a 64-point FFT; FFT_LOADER_BITREV_EN selects bit-reversed buffer order
module fft_frame_loader #(
   parameter int N           = 64,
   parameter int W           = 16,
   parameter int HOLD_CYCLES = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [W-1:0]     s_re,
   input  logic [W-1:0]     s_im,
   input  logic             flush,
   output logic [W-1:0]     fft_Re [N-1:0],
   output logic [W-1:0]     fft_Im [N-1:0],
   output logic             start,
   output logic             busy,
   output logic [$clog2(N):0] wr_count
);
   localparam int LOG2N = $clog2(N);
   localparam int CW    = $clog2(HOLD_CYCLES + 1);
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   typedef enum logic [1:0] {S_FILL, S_START, S_HOLD} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [LOG2N-1:0]   r_wr_idx;
   logic [LOG2N:0]     r_wr_count;
   logic [CW-1:0]      r_hold_cnt;
   logic               r_start;
   logic [W-1:0]       r_re [N-1:0];
   logic [W-1:0]       r_im [N-1:0];
   logic               w_s_ready;
   logic               w_accept;
   logic [LOG2N-1:0]   w_addr;

`ifdef FFT_LOADER_BITREV_EN
   always_comb begin
      w_addr = '0;
      for (int b = 0; b < LOG2N; b++) w_addr[b] = r_wr_idx[LOG2N-1-b];
   end
`else
   assign w_addr = r_wr_idx;
`endif

   assign w_accept = s_valid & w_s_ready;

   always_comb begin
      w_next    = r_state;
      w_s_ready = 1'b0;
      case (r_state)
         S_FILL: begin
            // reset gates ready so no sample is taken while the loader is held in reset
            w_s_ready = rst & ~flush;
            if (w_accept && (r_wr_idx == LAST_IDX)) w_next = S_START;
         end
         S_START: w_next = S_HOLD;
         S_HOLD:  if (r_hold_cnt == '0) w_next = S_FILL;
         default: w_next = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_FILL;
         r_wr_idx   <= '0;
         r_wr_count <= '0;
         r_hold_cnt <= '0;
         r_start    <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_re[i] <= '0;
            r_im[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_start <= (w_next == S_START);
         case (r_state)
            S_FILL: begin
               if (flush) begin
                  r_wr_idx   <= '0;
                  r_wr_count <= '0;
               end else if (w_accept) begin
                  r_re[w_addr] <= s_re;
                  r_im[w_addr] <= s_im;
                  r_wr_idx     <= r_wr_idx + 1'b1;
                  r_wr_count   <= r_wr_count + 1'b1;
               end
            end
            S_START: r_hold_cnt <= CW'(HOLD_CYCLES - 1);
            S_HOLD: begin
               if (r_hold_cnt == '0) begin
                  r_wr_idx   <= '0;
                  r_wr_count <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_ready  = w_s_ready;
   assign start    = r_start;
   assign busy     = (r_state != S_FILL);
   assign wr_count = r_wr_count;
   assign fft_Re   = r_re;
   assign fft_Im   = r_im;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - self-checking bench for fft_frame_loader against a frame-level reference model
module tb_fft_frame_loader;
   localparam int N = 64;
   localparam int W = 16;
   localparam int HOLD = 200;
   localparam int LOG2N = $clog2(N);

   logic clk, rst, s_valid, s_ready, flush, start, busy;
   logic [W-1:0] s_re, s_im;
   logic [W-1:0] fft_Re [N-1:0];
   logic [W-1:0] fft_Im [N-1:0];
   logic [LOG2N:0] wr_count;

   fft_frame_loader #(.N(N), .W(W), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_re(s_re), .s_im(s_im), .flush(flush),
      .fft_Re(fft_Re), .fft_Im(fft_Im), .start(start), .busy(busy),
      .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference: samples so far in the frame, and remaining cycles the loader is unavailable
   int mcount;
   int mblock;
   logic [W-1:0] mre [N];
   logic [W-1:0] mim [N];
   logic frame_every;

   logic obs_ready, obs_start, obs_acc, obs_busy;
   int obs_cnt;

   typedef struct {
      logic v;
      logic fl;
      logic [W-1:0] re;
      logic exp_ready;
      int exp_cnt;
   } vec_t;
   vec_t tbl [8];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int maddr(input int k);
`ifdef FFT_LOADER_BITREV_EN
      int r;
      int x;
      r = 0;
      x = k;
      for (int i = 0; i < LOG2N; i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
`else
      return k;
`endif
   endfunction

   task automatic model_reset();
      mcount = 0;
      mblock = 0;
      for (int i = 0; i < N; i++) begin
         mre[i] = '0;
         mim[i] = '0;
      end
   endtask

   task automatic check_frame(input string name);
      int bad_re;
      int bad_im;
      bad_re = 0;
      bad_im = 0;
      for (int i = 0; i < N; i++) begin
         if (fft_Re[i] !== mre[i]) bad_re++;
         if (fft_Im[i] !== mim[i]) bad_im++;
      end
      cmp({name, "_re_bad_entries"}, bad_re, 0);
      cmp({name, "_im_bad_entries"}, bad_im, 0);
   endtask

   // one clock: drive at posedge+1, check at posedge+3, advance model after the edge
   task automatic cycle(input logic v, input logic [W-1:0] re, input logic [W-1:0] im, input logic fl);
      logic e_ready;
      s_valid = v;
      s_re = re;
      s_im = im;
      flush = fl;
      #2;
      e_ready = rst && (mblock == 0) && !fl;
      cmp("s_ready", int'(s_ready), int'(e_ready));
      cmp("start", int'(start), int'(mblock == HOLD + 1));
      cmp("busy", int'(busy), int'(mblock > 0));
      cmp("wr_count", int'(wr_count), mcount);
      if (mblock == HOLD + 1 || mblock == 1 || (frame_every && mblock > 0)) check_frame("frame");
      obs_ready = s_ready;
      obs_start = start;
      obs_busy = busy;
      obs_acc = v && s_ready;
      obs_cnt = int'(wr_count);
      @(posedge clk);
      #1;
      cyc++;
      if (mblock > 0) begin
         mblock--;
         if (mblock == 0) mcount = 0;
      end else if (fl) begin
         mcount = 0;
      end else if (v && e_ready) begin
         mre[maddr(mcount)] = re;
         mim[maddr(mcount)] = im;
         mcount++;
         if (mcount == N) mblock = HOLD + 1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      s_valid = 1'b0;
      flush = 1'b0;
      s_re = '0;
      s_im = '0;
      model_reset();
      #2;
      cmp("rst_s_ready", int'(s_ready), 0);
      cmp("rst_start", int'(start), 0);
      cmp("rst_busy", int'(busy), 0);
      cmp("rst_wr_count", int'(wr_count), 0);
      check_frame("rst_frame");
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // idle until ready returns; reports blocked cycles, pulses seen and index of first pulse
   task automatic run_until_ready(output int low, output int starts, output int first_start);
      low = 0;
      starts = 0;
      first_start = -1;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b0, '0, '0, 1'b0);
         if (obs_start) begin
            starts++;
            if (first_start < 0) first_start = i;
         end
         if (obs_ready) break;
         low++;
      end
   endtask

   task automatic scenario1();
      int low, starts, fs, bad;
      for (int k = 0; k < N; k++) cycle(1'b1, (k < 32) ? 16'd4 : 16'd0, 16'd0, 1'b0);
      run_until_ready(low, starts, fs);
      cmp("s1_ready_low_cycles", low, HOLD + 1);
      cmp("s1_start_count", starts, 1);
      cmp("s1_start_latency", fs, 0);
      cmp("s1_wr_count_after", obs_cnt, 0);
`ifndef FFT_LOADER_BITREV_EN
      bad = 0;
      for (int k = 0; k < N; k++) if (fft_Re[k] !== ((k < 32) ? 16'd4 : 16'd0)) bad++;
      cmp("s1_const_re_bad", bad, 0);
`else
      bad = 0;
      for (int k = 0; k < N; k++) if (fft_Re[k] !== ((k % 2 == 0) ? 16'd4 : 16'd0)) bad++;
      cmp("s1_bitrev_re_bad", bad, 0);
`endif
   endtask

   initial begin
      int low, starts, fs, k, guard, bad, busy_seen;
      int st [$];
      logic [W-1:0] neg;

      tbl[0] = '{v:1'b1, fl:1'b0, re:16'd7, exp_ready:1'b1, exp_cnt:0};
      tbl[1] = '{v:1'b0, fl:1'b0, re:16'd7, exp_ready:1'b1, exp_cnt:1};
      tbl[2] = '{v:1'b1, fl:1'b0, re:16'd7, exp_ready:1'b1, exp_cnt:1};
      tbl[3] = '{v:1'b1, fl:1'b1, re:16'd8, exp_ready:1'b0, exp_cnt:2};
      tbl[4] = '{v:1'b1, fl:1'b0, re:16'd9, exp_ready:1'b1, exp_cnt:0};
      tbl[5] = '{v:1'b1, fl:1'b1, re:16'd8, exp_ready:1'b0, exp_cnt:1};
      tbl[6] = '{v:1'b0, fl:1'b0, re:16'd9, exp_ready:1'b1, exp_cnt:0};
      tbl[7] = '{v:1'b1, fl:1'b0, re:16'd9, exp_ready:1'b1, exp_cnt:0};

      frame_every = 1'b0;
      rst = 1'b0;
      s_valid = 1'b0;
      flush = 1'b0;
      s_re = '0;
      s_im = '0;
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].v, tbl[i].re, 16'd0, tbl[i].fl);
         cmp("tbl_ready", int'(obs_ready), int'(tbl[i].exp_ready));
         cmp("tbl_wr_count", obs_cnt, tbl[i].exp_cnt);
      end

      do_reset();
      scenario1();

      // gapped stream, sample k carries re=k, im=-k
      do_reset();
      k = 0;
      guard = 0;
      busy_seen = 0;
      while (k < N && guard < 2000) begin
         neg = W'(-k);
         cycle(1'($urandom % 2), W'(k), neg, 1'b0);
         if (obs_acc) k++;
         if (obs_busy) busy_seen++;
         guard++;
      end
      cmp("s2_samples_accepted", k, N);
      cmp("s2_busy_during_fill", busy_seen, 0);
      run_until_ready(low, starts, fs);
      cmp("s2_start_count", starts, 1);
`ifdef FFT_LOADER_BITREV_EN
      cmp("s3_re32", int'(fft_Re[32]), 1);
      cmp("s3_re1", int'(fft_Re[1]), 32);
      cmp("s3_re63", int'(fft_Re[63]), 63);
      cmp("s3_re0", int'(fft_Re[0]), 0);
`else
      bad = 0;
      for (int j = 0; j < N; j++) begin
         neg = W'(-j);
         if (fft_Re[j] !== W'(j) || fft_Im[j] !== neg) bad++;
      end
      cmp("s2_ramp_bad", bad, 0);
`endif

      // flush mid-frame
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 16'd7, 16'd0, 1'b0);
      cycle(1'b1, 16'd8, 16'd0, 1'b1);
      cmp("s4_flush_cycle_ready", int'(obs_ready), 0);
      cmp("s4_count_before_flush", obs_cnt, 10);
      cycle(1'b1, 16'd9, 16'd0, 1'b0);
      cmp("s4_count_after_flush", obs_cnt, 0);
      for (int i = 1; i < N; i++) cycle(1'b1, 16'd9, 16'd0, 1'b0);
      run_until_ready(low, starts, fs);
      cmp("s4_start_count", starts, 1);
      bad = 0;
      for (int j = 0; j < N; j++) if (fft_Re[j] !== 16'd9) bad++;
      cmp("s4_all_nine_bad", bad, 0);

      // reset 50 cycles into the hold window
      do_reset();
      for (int i = 0; i < N; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0);
      for (int i = 0; i < 50; i++) cycle(1'b0, '0, '0, 1'b0);
      cmp("s5_busy_before_reset", int'(obs_busy), 1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      cmp("s5_async_start", int'(start), 0);
      cmp("s5_async_busy", int'(busy), 0);
      cmp("s5_async_wr_count", int'(wr_count), 0);
      cmp("s5_async_ready", int'(s_ready), 0);
      check_frame("s5_async_frame");
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle(1'b0, '0, '0, 1'b0);
      cmp("s5_ready_after_reset", int'(obs_ready), 1);
      scenario1();

      // reset landing on the start pulse
      for (int i = 0; i < N; i++) cycle(1'b1, 16'd3, 16'd1, 1'b0);
      #2;
      cmp("s5b_start_high", int'(start), 1);
      rst = 1'b0;
      model_reset();
      #1;
      cmp("s5b_start_cleared", int'(start), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // two back-to-back frames with continuous valid
      do_reset();
      frame_every = 1'b1;
      guard = 0;
      while (st.size() < 2 && guard < 1000) begin
         cycle(1'b1, W'($urandom), W'($urandom), 1'b0);
         if (obs_start) st.push_back(cyc);
         guard++;
      end
      frame_every = 1'b0;
      cmp("s6_start_pulses", st.size(), 2);
      if (st.size() == 2) cmp("s6_start_spacing", st[1] - st[0], N + 1 + HOLD);

      // fully random traffic with occasional flush
      do_reset();
      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom % 2), W'($urandom), W'($urandom), 1'($urandom % 32 == 0));
      check_frame("rand_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
